rdb_subtractor: RTL and testbench

Pipelined recursive-doubling subtractor: computes diff = a − b − bin over WIDTH bits and produces a borrow-out and a zero flag. It is the subtraction counterpart of the 64-bit recursive-doubling adder in the Lab4 datapath and reuses that adder's kill/propagate/generate (KGP) doubling scheme, applied to borrows instead of carries. Operands enter through a valid/ready handshake and results leave through one. The doubling network is register-sliced for full throughput.

---
 rtl/kgp_pkg.sv | 22 ++
 rtl/kgp_level.sv | 20 ++
 rtl/rdb_subtractor.sv | 115 +++++++++++
 tb/tb_rdb_subtractor.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_pkg.sv
// Kill/propagate/generate encoding shared by the recursive-doubling adder and subtractor.
package kgp_pkg;

  typedef logic [1:0] kgp_t;

  localparam kgp_t KGP_KILL = 2'b00;
  localparam kgp_t KGP_PROP = 2'b01;
  localparam kgp_t KGP_GEN  = 2'b10;

  // Prefix operator: a propagating upper span takes its value from the span below it.
  function automatic kgp_t kgp_combine(input kgp_t hi, input kgp_t lo);
    return (hi == KGP_PROP) ? lo : hi;
  endfunction

  // Borrow classification of one subtraction bit position (a - b).
  function automatic kgp_t kgp_sub_bit(input logic a_bit, input logic b_bit);
    if (a_bit && !b_bit) return KGP_KILL;
    if (!a_bit && b_bit) return KGP_GEN;
    return KGP_PROP;
  endfunction

endpackage

// File: rtl/kgp_level.sv
// One combinational recursive-doubling level at distance D over a WIDTH-entry KGP vector.
module kgp_level
  import kgp_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int D     = 1
) (
  input  kgp_t [WIDTH-1:0] kgp_in,
  output kgp_t [WIDTH-1:0] kgp_out
);

  for (genvar j = 0; j < WIDTH; j++) begin : g_bit
    if (j < D) begin : g_pass
      assign kgp_out[j] = kgp_in[j];
    end else begin : g_comb
      assign kgp_out[j] = kgp_combine(kgp_in[j], kgp_in[j-D]);
    end
  end

endmodule

// File: rtl/rdb_subtractor.sv
// Pipelined recursive-doubling subtractor: diff = a - b - bin, with borrow-out and zero flag.
// Stage S1 forms per-bit KGP, each later stage resolves two doubling levels, the last also forms the sum.
module rdb_subtractor
  import kgp_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int P      = (LEVELS + 1) / 2;

  // Handshake: a word moves on any edge where valid && ready. The whole pipe freezes
  // (valid bits included) while a result sits unaccepted, so in_ready = !stall and
  // that is the only combinational input-to-output path.
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  kgp_t [WIDTH-1:0] kgp_in_vec;
  kgp_t [WIDTH-1:0] kgp_q     [P];
  kgp_t [WIDTH-1:0] stage_out [P];
  logic [WIDTH-1:0] a_q       [P];
  logic [WIDTH-1:0] b_q       [P];
  logic             bin_q     [P];
  logic             v_q       [P];

  // Bit 0 folds borrow-in: a matching pair borrows exactly when bin does.
  always_comb begin
    kgp_in_vec = '0;
    if (a[0] != b[0]) kgp_in_vec[0] = kgp_sub_bit(a[0], b[0]);
    else              kgp_in_vec[0] = bin ? KGP_GEN : KGP_KILL;
    for (int i = 1; i < WIDTH; i++) begin
      kgp_in_vec[i] = kgp_sub_bit(a[i], b[i]);
    end
  end

  for (genvar s = 0; s < P; s++) begin : g_stage
    kgp_t [WIDTH-1:0] mid;
    kgp_t [WIDTH-1:0] lout;

    kgp_level #(.WIDTH(WIDTH), .D(1 << (2 * s))) u_lvl_lo (
      .kgp_in  (kgp_q[s]),
      .kgp_out (mid)
    );

    if (2 * s + 1 < LEVELS) begin : g_two
      kgp_level #(.WIDTH(WIDTH), .D(1 << (2 * s + 1))) u_lvl_hi (
        .kgp_in  (mid),
        .kgp_out (lout)
      );
    end else begin : g_one
      assign lout = mid;
    end

    assign stage_out[s] = lout;
  end

  logic [WIDTH-1:0] borrow;
  logic [WIDTH-1:0] diff_next;

  always_comb begin
    borrow = '0;
    for (int i = 0; i < WIDTH; i++) begin
      borrow[i] = (stage_out[P-1][i] == KGP_GEN);
    end
    diff_next = a_q[P-1] ^ b_q[P-1] ^ {borrow[WIDTH-2:0], bin_q[P-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < P; s++) begin
        v_q[s]   <= 1'b0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        bin_q[s] <= 1'b0;
        kgp_q[s] <= '0;
      end
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
    end else if (!stall) begin
      v_q[0]   <= in_valid;
      a_q[0]   <= a;
      b_q[0]   <= b;
      bin_q[0] <= bin;
      kgp_q[0] <= kgp_in_vec;
      for (int s = 1; s < P; s++) begin
        v_q[s]   <= v_q[s-1];
        a_q[s]   <= a_q[s-1];
        b_q[s]   <= b_q[s-1];
        bin_q[s] <= bin_q[s-1];
        kgp_q[s] <= stage_out[s-1];
      end
      out_valid <= v_q[P-1];
      diff      <= diff_next;
      bout      <= borrow[WIDTH-1];
      zero      <= (diff_next == '0);
    end
  end

endmodule

// File: tb/tb_rdb_subtractor.sv
// Self-checking bench for rdb_subtractor (WIDTH=64) against an arithmetic reference model.
module tb_rdb_subtractor;

  localparam int W   = 64;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Expected results as {zero, bout, diff}, oldest first.
  logic [W+1:0] exp_q[$];

  rdb_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
    logic [W:0] r;
    r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    return {(r[W-1:0] == '0), r[W], r[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  // Drive one cycle: apply inputs, sample outputs before the edge, then advance past it.
  task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ibin, input logic ordy,
                       output logic ir, output logic ov, output logic [W-1:0] od,
                       output logic ob, output logic oz);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    bin       = ibin;
    out_ready = ordy;
    #1;
    ir = in_ready;
    ov = out_valid;
    od = diff;
    ob = bout;
    oz = zero;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    vec_cnt++;
    if ({zero, bout, diff} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got zero=%b bout=%b diff=%h expected all 0", zero, bout, diff);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed;
    logic [W-1:0] ta[4];
    logic [W-1:0] tb_v[4];
    logic [W-1:0] td[4];
    logic         tbin[4];
    logic         tbo[4];
    logic         tz[4];
    logic         ir, ov, ob, oz;
    logic [W-1:0] od;
    logic [W+1:0] got;
    int           lat;
    ta[0] = 64'd5;                 tb_v[0] = 64'd3;                 tbin[0] = 1'b0;
    td[0] = 64'd2;                 tbo[0] = 1'b0;                   tz[0] = 1'b0;
    ta[1] = 64'd0;                 tb_v[1] = 64'd1;                 tbin[1] = 1'b0;
    td[1] = 64'hFFFF_FFFF_FFFF_FFFF; tbo[1] = 1'b1;                 tz[1] = 1'b0;
    ta[2] = 64'h8000_0000_0000_0000; tb_v[2] = 64'h8000_0000_0000_0000; tbin[2] = 1'b1;
    td[2] = 64'hFFFF_FFFF_FFFF_FFFF; tbo[2] = 1'b1;                 tz[2] = 1'b0;
    ta[3] = 64'h8000_0000_0000_0000; tb_v[3] = 64'h8000_0000_0000_0000; tbin[3] = 1'b0;
    td[3] = 64'd0;                 tbo[3] = 1'b0;                   tz[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, ta[k], tb_v[k], tbin[k], 1'b1, ir, ov, od, ob, oz);
      lat = -1;
      got = '0;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
        cycle(1'b0, '0, '0, 1'b0, 1'b1, ir, ov, od, ob, oz);
        if (ov) begin
          lat = c;
          got = {oz, ob, od};
        end
      end
      vec_cnt++;
      if (lat != LAT) begin
        err_cnt++;
        $display("FAIL directed_latency[%0d]: got %0d expected %0d", k, lat, LAT);
      end
      vec_cnt++;
      if (got !== {tz[k], tbo[k], td[k]}) begin
        err_cnt++;
        $display("FAIL directed_result[%0d]: got zero=%b bout=%b diff=%h expected zero=%b bout=%b diff=%h",
                 k, got[W+1], got[W], got[W-1:0], tz[k], tbo[k], td[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] opa[8];
    logic [W-1:0] opb[8];
    logic         opbin[8];
    logic         ir, ov, ob, oz, ordy, iv;
    logic [W-1:0] od;
    logic [W+1:0] held, want;
    int           pushed, popped, stall_left, idx;
    for (int k = 0; k < 8; k++) begin
      opa[k]   = rand_word();
      opb[k]   = (k % 3 == 0) ? opa[k] : rand_word();
      opbin[k] = 1'($urandom_range(0, 1));
    end
    pushed     = 0;
    popped     = 0;
    stall_left = -1;
    held       = '0;
    for (int c = 0; c < 60 && popped < 8; c++) begin
      if (stall_left < 0 && out_valid) stall_left = 3;
      ordy = !(stall_left > 0);
      iv   = (pushed < 8);
      idx  = (pushed < 8) ? pushed : 0;
      cycle(iv, opa[idx], opb[idx], opbin[idx], ordy, ir, ov, od, ob, oz);
      if (!ordy) begin
        vec_cnt++;
        if (ir !== 1'b0) begin
          err_cnt++;
          $display("FAIL b2b_stall_in_ready: got %b expected 0", ir);
        end
        if (stall_left == 3) begin
          held = {oz, ob, od};
        end else begin
          vec_cnt++;
          if ({oz, ob, od} !== held) begin
            err_cnt++;
            $display("FAIL b2b_stall_hold: got %h expected %h", {oz, ob, od}, held);
          end
        end
        stall_left--;
      end
      if (ov && ordy) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL b2b_unexpected: got %h expected no result", {oz, ob, od});
        end else begin
          want = exp_q.pop_front();
          if ({oz, ob, od} !== want) begin
            err_cnt++;
            $display("FAIL b2b_result[%0d]: got %h expected %h", popped, {oz, ob, od}, want);
          end
        end
        popped++;
      end
      if (iv && ir) begin
        exp_q.push_back(ref_model(opa[idx], opb[idx], opbin[idx]));
        pushed++;
      end
    end
    vec_cnt++;
    if (popped != 8 || pushed != 8 || exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL b2b_count: got popped=%0d pushed=%0d pending=%0d expected 8 8 0",
               popped, pushed, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_in_flight;
    logic         ir, ov, ob, oz;
    logic [W-1:0] od, xa, xb;
    logic [W+1:0] got, want;
    int           stale, lat;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, rand_word(), rand_word(), 1'($urandom_range(0, 1)), 1'b1, ir, ov, od, ob, oz);
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b0, ir, ov, od, ob, oz);
    vec_cnt++;
    if (out_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL rif_pre_valid: got %b expected 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL rif_async_clear: got %b expected 0", out_valid);
    end
    #4;
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, ir, ov, od, ob, oz);
      if (c == 0) begin
        vec_cnt++;
        if (ir !== 1'b1) begin
          err_cnt++;
          $display("FAIL rif_in_ready: got %b expected 1", ir);
        end
      end
      if (ov) stale++;
    end
    vec_cnt++;
    if (stale != 0) begin
      err_cnt++;
      $display("FAIL rif_stale: got %0d results expected 0", stale);
    end
    xa   = rand_word();
    xb   = rand_word();
    want = ref_model(xa, xb, 1'b1);
    cycle(1'b1, xa, xb, 1'b1, 1'b1, ir, ov, od, ob, oz);
    lat = -1;
    got = '0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, ir, ov, od, ob, oz);
      if (ov) begin
        lat = c;
        got = {oz, ob, od};
      end
    end
    vec_cnt++;
    if (lat != LAT || got !== want) begin
      err_cnt++;
      $display("FAIL rif_after: got lat=%0d res=%h expected lat=%0d res=%h", lat, got, LAT, want);
    end
  endtask

  task automatic test_random;
    logic         ir, ov, ob, oz, iv, ordy, hold, prev_stall, xbin;
    logic [W-1:0] od, xa, xb;
    logic [W+1:0] prev_out, want;
    int           pushed;
    pushed     = 0;
    hold       = 1'b0;
    prev_stall = 1'b0;
    prev_out   = '0;
    xa         = '0;
    xb         = '0;
    xbin       = 1'b0;
    for (int c = 0; c < 8000 && (pushed < 1000 || exp_q.size() > 0); c++) begin
      if (!hold) begin
        xa   = rand_word();
        xb   = ($urandom_range(0, 3) == 0) ? xa : rand_word();
        xbin = 1'($urandom_range(0, 1));
      end
      iv   = hold || (pushed < 1000 && $urandom_range(0, 9) < 8);
      ordy = (pushed >= 1000) || ($urandom_range(0, 9) < 7);
      cycle(iv, xa, xb, xbin, ordy, ir, ov, od, ob, oz);
      if (prev_stall) begin
        vec_cnt++;
        if (!ov || {oz, ob, od} !== prev_out) begin
          err_cnt++;
          $display("FAIL rand_hold: got valid=%b res=%h expected valid=1 res=%h", ov, {oz, ob, od}, prev_out);
        end
      end
      if (ov && ordy) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL rand_unexpected: got %h expected no result", {oz, ob, od});
        end else begin
          want = exp_q.pop_front();
          if ({oz, ob, od} !== want) begin
            err_cnt++;
            $display("FAIL rand_result: got %h expected %h", {oz, ob, od}, want);
          end
        end
      end
      if (iv && ir) begin
        exp_q.push_back(ref_model(xa, xb, xbin));
        pushed++;
      end
      prev_stall = ov && !ordy;
      prev_out   = {oz, ob, od};
      hold       = iv && !ir;
    end
    vec_cnt++;
    if (pushed != 1000 || exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL rand_drain: got pushed=%0d pending=%0d expected 1000 0", pushed, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_in_flight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
